// File: rtl/ofs_asp_pkg.sv
// ofs_asp_pkg: shared ASP types and constants for the host-memory read throttle.
package ofs_asp_pkg;

    typedef enum logic {
        THR_IDLE,
        THR_WR_BURST
    } t_hostmem_thr_state;

    localparam int ASP_HOSTMEM_MAX_RD_BEATS = 512;

endpackage

// File: rtl/ofs_asp_hostmem_thr_stats.sv
// ofs_asp_hostmem_thr_stats: saturating credit-stall counter and peak outstanding-read tracker.
`ifdef ASP_HOSTMEM_RD_THROTTLE_STATS_EN
module ofs_asp_hostmem_thr_stats #(
    parameter int RW = 10
) (
    input  logic          afu_clk,
    input  logic          afu_reset_n,
    input  logic          stall,
    input  logic          clr,
    input  logic [RW-1:0] rd_out,
    output logic [31:0]   stat_stall_cycles,
    output logic [RW-1:0] stat_peak_rd_out
);

    always_ff @(posedge afu_clk or negedge afu_reset_n) begin
        if (!afu_reset_n) begin
            stat_stall_cycles <= '0;
            stat_peak_rd_out  <= '0;
        end else if (clr) begin
            stat_stall_cycles <= '0;
            stat_peak_rd_out  <= '0;
        end else begin
            if (stall && stat_stall_cycles != '1)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            if (rd_out > stat_peak_rd_out)
                stat_peak_rd_out <= rd_out;
        end
    end

endmodule
`endif

// File: rtl/ofs_asp_hostmem_rd_throttle.sv
// ofs_asp_hostmem_rd_throttle: read-credit throttle with atomic write bursts and drain/idle handshake.
// Define ASP_HOSTMEM_RD_THROTTLE_STATS_EN to add stall/peak statistics outputs.
module ofs_asp_hostmem_rd_throttle
    import ofs_asp_pkg::*;
#(
    parameter int ADDR_WIDTH      = 42,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 6,
    parameter int MAX_RD_BEATS    = ASP_HOSTMEM_MAX_RD_BEATS
) (
    input  logic                       afu_clk,
    input  logic                       afu_reset_n,
    input  logic [ADDR_WIDTH-1:0]      s_address,
    input  logic                       s_read,
    input  logic                       s_write,
    input  logic [BURST_CNT_WIDTH-1:0] s_burstcount,
    input  logic [DATA_WIDTH-1:0]      s_writedata,
    input  logic [DATA_WIDTH/8-1:0]    s_byteenable,
    output logic                       s_waitrequest,
    output logic [DATA_WIDTH-1:0]      s_readdata,
    output logic                       s_readdatavalid,
    output logic [ADDR_WIDTH-1:0]      m_address,
    output logic                       m_read,
    output logic                       m_write,
    output logic [BURST_CNT_WIDTH-1:0] m_burstcount,
    output logic [DATA_WIDTH-1:0]      m_writedata,
    output logic [DATA_WIDTH/8-1:0]    m_byteenable,
    input  logic                       m_waitrequest,
    input  logic [DATA_WIDTH-1:0]      m_readdata,
    input  logic                       m_readdatavalid,
    input  logic                       drain,
    output logic                       idle,
    output logic                       err_underflow
`ifdef ASP_HOSTMEM_RD_THROTTLE_STATS_EN
    ,
    output logic [31:0]                        stat_stall_cycles,
    output logic [$clog2(MAX_RD_BEATS+1)-1:0]  stat_peak_rd_out
`endif
);

    localparam int RW = $clog2(MAX_RD_BEATS + 1);

    t_hostmem_thr_state         state;
    logic [RW-1:0]              rd_out;
    logic [BURST_CNT_WIDTH-1:0] wr_left;
    logic [RW:0]                rd_sum;
    logic [RW-1:0]              rd_inc;
    logic [RW-1:0]              rd_dec;
    logic                       in_burst;
    logic                       rd_block;
    logic                       wr_block;
    logic                       rd_acc;
    logic                       wr_acc;
    logic                       rd_ret;

    assign in_burst = state == THR_WR_BURST;
    assign rd_sum   = {1'b0, rd_out} + (RW+1)'(s_burstcount);
    assign rd_block = drain | in_burst | (rd_sum > (RW+1)'(MAX_RD_BEATS));
    assign wr_block = drain & ~in_burst;

    // A write presented together with a read wins; the read is never forwarded.
    assign m_read        = s_read & ~s_write & ~rd_block;
    assign m_write       = s_write & ~wr_block;
    assign s_waitrequest = m_waitrequest | (s_read & rd_block) | (s_write & wr_block);

    assign m_address       = s_address;
    assign m_burstcount    = s_burstcount;
    assign m_writedata     = s_writedata;
    assign m_byteenable    = s_byteenable;
    assign s_readdata      = m_readdata;
    assign s_readdatavalid = m_readdatavalid;

    assign rd_acc = m_read & ~m_waitrequest;
    assign wr_acc = m_write & ~m_waitrequest;
    assign rd_ret = m_readdatavalid & (rd_out != '0);
    assign rd_inc = rd_acc ? RW'(s_burstcount) : '0;
    assign rd_dec = RW'(rd_ret);
    assign idle   = (rd_out == '0) & ~in_burst;

    always_ff @(posedge afu_clk or negedge afu_reset_n) begin
        if (!afu_reset_n) begin
            state         <= THR_IDLE;
            rd_out        <= '0;
            wr_left       <= '0;
            err_underflow <= 1'b0;
        end else begin
            rd_out <= rd_out + rd_inc - rd_dec;
            if (m_readdatavalid && rd_out == '0)
                err_underflow <= 1'b1;
            if (wr_acc && in_burst) begin
                wr_left <= wr_left - BURST_CNT_WIDTH'(1);
                if (wr_left == BURST_CNT_WIDTH'(1))
                    state <= THR_IDLE;
            end else if (wr_acc && s_burstcount > BURST_CNT_WIDTH'(1)) begin
                state   <= THR_WR_BURST;
                wr_left <= s_burstcount - BURST_CNT_WIDTH'(1);
            end
        end
    end

`ifdef ASP_HOSTMEM_RD_THROTTLE_STATS_EN
    ofs_asp_hostmem_thr_stats #(
        .RW (RW)
    ) u_stats (
        .afu_clk           (afu_clk),
        .afu_reset_n       (afu_reset_n),
        .stall             (s_read & rd_block & ~drain),
        .clr               (drain & idle),
        .rd_out            (rd_out),
        .stat_stall_cycles (stat_stall_cycles),
        .stat_peak_rd_out  (stat_peak_rd_out)
    );
`endif

endmodule

// File: tb/tb_ofs_asp_hostmem_rd_throttle.sv
// tb_ofs_asp_hostmem_rd_throttle: directed plus randomized bench against an outstanding-beat reference model.
module tb_ofs_asp_hostmem_rd_throttle;

    localparam int AW   = 42;
    localparam int DW   = 512;
    localparam int BW   = 6;
    localparam int MAXB = 512;
    localparam int RW   = $clog2(MAXB + 1);

    logic          afu_clk = 1'b0;
    logic          afu_reset_n = 1'b0;
    logic [AW-1:0] s_address = '0;
    logic          s_read = 1'b0;
    logic          s_write = 1'b0;
    logic [BW-1:0] s_burstcount = BW'(1);
    logic [DW-1:0] s_writedata = '0;
    logic [DW/8-1:0] s_byteenable = '0;
    logic          s_waitrequest;
    logic [DW-1:0] s_readdata;
    logic          s_readdatavalid;
    logic [AW-1:0] m_address;
    logic          m_read;
    logic          m_write;
    logic [BW-1:0] m_burstcount;
    logic [DW-1:0] m_writedata;
    logic [DW/8-1:0] m_byteenable;
    logic          m_waitrequest = 1'b0;
    logic [DW-1:0] m_readdata = '0;
    logic          m_readdatavalid = 1'b0;
    logic          drain = 1'b0;
    logic          idle;
    logic          err_underflow;
`ifdef ASP_HOSTMEM_RD_THROTTLE_STATS_EN
    logic [31:0]   stat_stall_cycles;
    logic [RW-1:0] stat_peak_rd_out;
    int unsigned   ref_stall;
    int            ref_peak;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int outst;
    int burst_left;
    bit ref_err;

    ofs_asp_hostmem_rd_throttle dut (
        .afu_clk         (afu_clk),
        .afu_reset_n     (afu_reset_n),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_burstcount    (s_burstcount),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_burstcount    (m_burstcount),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .drain           (drain),
        .idle            (idle),
        .err_underflow   (err_underflow)
`ifdef ASP_HOSTMEM_RD_THROTTLE_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_peak_rd_out  (stat_peak_rd_out)
`endif
    );

    always #5 afu_clk = ~afu_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input bit rd, input bit wr, input int bc);
        s_read       = rd;
        s_write      = wr;
        s_burstcount = BW'(bc);
        s_address    = AW'({$urandom, $urandom});
        s_writedata  = {16{$urandom}};
        s_byteenable = {$urandom, $urandom};
        m_readdata   = {16{$urandom}};
    endtask

    // Checks every output against the model, then advances one clock and updates the model.
    task automatic step();
        bit in_b, rblk, wblk, er, ew;
        #2;
        in_b = burst_left > 0;
        rblk = drain || in_b || (outst + int'(s_burstcount) > MAXB);
        wblk = drain && !in_b;
        er   = s_read && !s_write && !rblk;
        ew   = s_write && !wblk;
        check("m_read", m_read, er);
        check("m_write", m_write, ew);
        check("s_waitrequest", s_waitrequest, m_waitrequest || (s_read && rblk) || (s_write && wblk));
        check("idle", idle, outst == 0 && !in_b);
        check("err_underflow", err_underflow, ref_err);
        check("m_address", m_address, s_address);
        check("m_burstcount", m_burstcount, s_burstcount);
        check("m_writedata", m_writedata[63:0], s_writedata[63:0]);
        check("m_byteenable", m_byteenable, s_byteenable);
        check("s_readdata", s_readdata[63:0], m_readdata[63:0]);
        check("s_readdatavalid", s_readdatavalid, m_readdatavalid);
`ifdef ASP_HOSTMEM_RD_THROTTLE_STATS_EN
        check("stat_stall_cycles", stat_stall_cycles, ref_stall);
        check("stat_peak_rd_out", stat_peak_rd_out, ref_peak);
`endif
        @(posedge afu_clk);
`ifdef ASP_HOSTMEM_RD_THROTTLE_STATS_EN
        if (drain && outst == 0 && !in_b) begin
            ref_stall = 0;
            ref_peak  = 0;
        end else begin
            if (s_read && rblk && !drain && ref_stall != 32'hFFFF_FFFF) ref_stall++;
            if (outst > ref_peak) ref_peak = outst;
        end
`endif
        if (m_readdatavalid) begin
            if (outst == 0) ref_err = 1'b1;
            else outst--;
        end
        if (er && !m_waitrequest) outst += int'(s_burstcount);
        if (ew && !m_waitrequest) begin
            if (in_b) burst_left--;
            else if (s_burstcount > 1) burst_left = int'(s_burstcount) - 1;
        end
        #1;
    endtask

    task automatic do_reset();
        set_cmd(0, 0, 1);
        drain = 0;
        m_waitrequest = 0;
        m_readdatavalid = 0;
        afu_reset_n = 0;
        #2;
        check("rst_idle", idle, 1);
        check("rst_err", err_underflow, 0);
        check("rst_wait", s_waitrequest, 0);
        check("rst_rd_out", dut.rd_out, 0);
        outst = 0;
        burst_left = 0;
        ref_err = 0;
`ifdef ASP_HOSTMEM_RD_THROTTLE_STATS_EN
        ref_stall = 0;
        ref_peak = 0;
`endif
        @(posedge afu_clk);
        @(posedge afu_clk);
        #1;
        afu_reset_n = 1;
    endtask

    task automatic flush();
        int guard = 0;
        set_cmd(0, 0, 1);
        m_waitrequest = 0;
        m_readdatavalid = 1;
        while (outst > 0 && guard < 2000) begin
            step();
            guard++;
        end
        m_readdatavalid = 0;
        check("flush_done", dut.rd_out, 0);
    endtask

    initial begin
        @(posedge afu_clk);
        #1;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            set_cmd(1, 0, 32);
            step();
        end
        check("rd_out_full", dut.rd_out, 512);
        set_cmd(1, 0, 32);
        for (int i = 0; i < 5; i++) step();
        check("stall17", s_waitrequest, 1);
`ifdef ASP_HOSTMEM_RD_THROTTLE_STATS_EN
        check("stats_stall5", stat_stall_cycles, 5);
        check("stats_peak512", stat_peak_rd_out, 512);
`endif
        m_readdatavalid = 1;
        step();
        #1;
        check("stall_after_one_ret", s_waitrequest, 1);
        for (int i = 0; i < 31; i++) step();
        m_readdatavalid = 0;
        #1;
        check("unstall_after_32", s_waitrequest, 0);
        step();
        check("rd_out_refill", dut.rd_out, 512);

        flush();
        set_cmd(0, 1, 8);
        for (int i = 0; i < 3; i++) step();
        set_cmd(1, 0, 4);
        #1;
        check("rd_held_in_burst", m_read, 0);
        check("rd_wait_in_burst", s_waitrequest, 1);
        step();
        step();
        set_cmd(0, 1, 8);
        step();
        step();
        drain = 1;
        for (int i = 0; i < 3; i++) step();
        drain = 0;
        set_cmd(1, 0, 4);
        #1;
        check("rd_after_burst", m_read, 1);
        step();
        check("rd_out_after_burst", dut.rd_out, 4);
        drain = 1;
        set_cmd(0, 1, 4);
        #1;
        check("drain_blocks_wr", m_write, 0);
        check("drain_wr_wait", s_waitrequest, 1);
        step();
        drain = 0;

        flush();
        set_cmd(1, 0, 10);
        step();
        set_cmd(1, 0, 4);
        m_readdatavalid = 1;
        step();
        m_readdatavalid = 0;
        check("rd_out_13", dut.rd_out, 13);

        flush();
        set_cmd(1, 0, 32);
        step();
        set_cmd(1, 0, 8);
        step();
        drain = 1;
        set_cmd(1, 0, 1);
        m_readdatavalid = 1;
        for (int i = 0; i < 40; i++) begin
            #1;
            check("drain_not_idle", idle, 0);
            check("drain_no_read", m_read, 0);
            step();
        end
        m_readdatavalid = 0;
        #1;
        check("drain_idle", idle, 1);
        step();
`ifdef ASP_HOSTMEM_RD_THROTTLE_STATS_EN
        check("stats_clr_stall", stat_stall_cycles, 0);
        check("stats_clr_peak", stat_peak_rd_out, 0);
`endif
        drain = 0;

        set_cmd(0, 0, 1);
        m_readdatavalid = 1;
        step();
        m_readdatavalid = 0;
        check("underflow_set", err_underflow, 1);
        check("underflow_rd_out", dut.rd_out, 0);
        for (int i = 0; i < 3; i++) step();
        check("underflow_sticky", err_underflow, 1);
        do_reset();

        for (int c = 0; c < 3000; c++) begin
            int op = $urandom_range(0, 9);
            bit rd = op < 4 || op == 9;
            bit wr = op == 9 || (op >= 4 && op < 7) || (burst_left > 0 && op < 9 && !rd);
            set_cmd(rd, wr, $urandom_range(1, 32));
            drain = $urandom_range(0, 19) == 0;
            m_waitrequest = $urandom_range(0, 3) == 0;
            m_readdatavalid = outst > 0 && $urandom_range(0, 2) != 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
